// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: 8-digit common-anode seven-segment refresh scanner with an
// 8-entry pattern buffer shared by two writers through a round-robin arbiter.
module seg_scan_arbiter #(
   parameter int N = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       req0,
   input  logic [2:0] idx0,
   input  logic [6:0] seg0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [2:0] idx1,
   input  logic [6:0] seg1,
   output logic       gnt1,
   output logic [6:0] CA,
   output logic [7:0] AN,
   output logic       frame_tick
);

   localparam logic [N-1:0] PRESC_MAX = {N{1'b1}};

   logic [N-1:0] presc_r;
   logic [2:0]   digit_r;
   logic         last_gnt_r;      // 1'b1: client 1 granted most recently
   logic [6:0]   seg_buf_r [8];
   logic         gnt0_s;
   logic         gnt1_s;

   // Active-low anode pattern selecting one digit.
   function automatic logic [7:0] anode_sel(input logic [2:0] d);
      return ~(8'b0000_0001 << d);
   endfunction

   // Round-robin grant: a lone requester wins, a tie goes to whoever lost last time.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (rst) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (req0 && req1) begin
         gnt0_s = last_gnt_r;
         gnt1_s = ~last_gnt_r;
      end else begin
         gnt0_s = req0;
         gnt1_s = req1;
      end
   end

   assign gnt0 = gnt0_s;
   assign gnt1 = gnt1_s;

   // Remember the most recent winner; reset leaves client 0 favoured.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt_r <= 1'b1;
      end else if (gnt0_s) begin
         last_gnt_r <= 1'b0;
      end else if (gnt1_s) begin
         last_gnt_r <= 1'b1;
      end else begin
         last_gnt_r <= last_gnt_r;
      end
   end

   // Pattern buffer: commit the granted client's write, independent of en.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            seg_buf_r[i] <= 7'h00;
         end
      end else if (gnt0_s) begin
         seg_buf_r[idx0] <= seg0;
      end else if (gnt1_s) begin
         seg_buf_r[idx1] <= seg1;
      end else begin
         seg_buf_r[idx0] <= seg_buf_r[idx0];
      end
   end

   // Scan timing: prescaler and digit counter advance only while enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= {N{1'b0}};
         digit_r <= 3'd0;
      end else if (en) begin
         if (presc_r == PRESC_MAX) begin
            presc_r <= {N{1'b0}};
            digit_r <= digit_r + 3'd1;
         end else begin
            presc_r <= presc_r + {{(N-1){1'b0}}, 1'b1};
            digit_r <= digit_r;
         end
      end else begin
         presc_r <= presc_r;
         digit_r <= digit_r;
      end
   end

   // Display outputs lag the digit counter by one cycle; a frame starts when
   // digit 0 lights directly after digit 7, so resume-from-blank never ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         CA         <= 7'h7F;
         AN         <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         CA <= ~seg_buf_r[digit_r];
         if (en) begin
            AN         <= anode_sel(digit_r);
            frame_tick <= (digit_r == 3'd0) && (AN == 8'h7F);
         end else begin
            AN         <= 8'hFF;
            frame_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: randomized stimulus against a behavioural display model.
module tb_seg_scan_arbiter;

   localparam int N = 1;
   localparam int DWELL = 1 << N;

   logic       clk = 1'b0;
   logic       rst, en;
   logic       req0, req1, gnt0, gnt1;
   logic [2:0] idx0, idx1;
   logic [6:0] seg0, seg1;
   logic [6:0] CA;
   logic [7:0] AN;
   logic       frame_tick;

   seg_scan_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst), .en(en),
      .req0(req0), .idx0(idx0), .seg0(seg0), .gnt0(gnt0),
      .req1(req1), .idx1(idx1), .seg1(seg1), .gnt1(gnt1),
      .CA(CA), .AN(AN), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: enabled-edge count since reset gives the scanned digit.
   int         en_cnt;
   logic [6:0] mbuf [8];
   int         last_winner;   // client granted most recently (1 after reset)
   logic [7:0] m_an;
   logic [6:0] m_ca;
   logic       m_ft;
   logic       m_g0, m_g1;
   int         frames_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_digit();
      return (en_cnt / DWELL) % 8;
   endfunction

   // Expected grants for the current inputs.
   task automatic model_grants();
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (!rst) begin
         if (req0 && req1) begin
            if (last_winner == 0) m_g1 = 1'b1;
            else                  m_g0 = 1'b1;
         end else begin
            m_g0 = req0;
            m_g1 = req1;
         end
      end
   endtask

   // Advance model across one clock edge using pre-edge inputs.
   task automatic model_edge();
      int d;
      logic [7:0] new_an;
      if (rst) begin
         en_cnt = 0;
         for (int i = 0; i < 8; i++) mbuf[i] = 7'h00;
         last_winner = 1;
         m_an = 8'hFF;
         m_ca = 7'h7F;
         m_ft = 1'b0;
      end else begin
         d = model_digit();
         new_an = en ? ~(8'h01 << d) : 8'hFF;
         m_ft = (new_an == 8'hFE) && (m_an == 8'h7F);
         m_an = new_an;
         m_ca = ~mbuf[d];
         if (m_g0) begin mbuf[idx0] = seg0; last_winner = 0; end
         if (m_g1) begin mbuf[idx1] = seg1; last_winner = 1; end
         if (en) en_cnt++;
      end
   endtask

   // One cycle: check grants before the edge, outputs just after it.
   task automatic cycle();
      #1;
      model_grants();
      check("gnt0", {31'b0, gnt0}, {31'b0, m_g0});
      check("gnt1", {31'b0, gnt1}, {31'b0, m_g1});
      check("gnt_excl", {31'b0, gnt0 & gnt1}, 32'd0);
      @(posedge clk);
      model_edge();
      #1;
      check("AN", {24'b0, AN}, {24'b0, m_an});
      check("CA", {25'b0, CA}, {25'b0, m_ca});
      check("frame_tick", {31'b0, frame_tick}, {31'b0, m_ft});
      if (m_ft) frames_seen++;
   endtask

   initial begin
      int both_cnt;
      frames_seen = 0;
      rst = 1'b1; en = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      idx0 = 3'd0; idx1 = 3'd0; seg0 = 7'h00; seg1 = 7'h00;
      en_cnt = 0; last_winner = 1;
      m_an = 8'hFF; m_ca = 7'h7F; m_ft = 1'b0;
      for (int i = 0; i < 8; i++) mbuf[i] = 7'h00;
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;

      // Idle scan: two full frames plus margin.
      for (int i = 0; i < 40; i++) cycle();
      check("idle_frames", frames_seen, 32'd2);

      // Single write of "0" to digit 3.
      req0 = 1'b1; idx0 = 3'd3; seg0 = 7'h3F;
      cycle();
      req0 = 1'b0;
      for (int i = 0; i < 20; i++) cycle();

      // Both clients requesting continuously: grants must alternate.
      rst = 1'b1; cycle(); rst = 1'b0;
      req0 = 1'b1; idx0 = 3'd0; seg0 = 7'h06;
      req1 = 1'b1; idx1 = 3'd1; seg1 = 7'h5B;
      both_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("alt_gnt0", {31'b0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         cycle();
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 20; i++) cycle();

      // Reset mid-frame with req1 held.
      req1 = 1'b1; idx1 = 3'd4; seg1 = 7'h66;
      rst = 1'b1; cycle(); rst = 1'b0;
      #1;
      check("gnt1_after_rst", {31'b0, gnt1}, 32'd1);
      cycle();
      req1 = 1'b0;

      // Randomized mix of requests, enable gaps and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         req0 = ($urandom_range(0, 2) == 0);
         req1 = ($urandom_range(0, 2) == 0);
         idx0 = 3'($urandom_range(0, 7));
         idx1 = 3'($urandom_range(0, 7));
         seg0 = 7'($urandom);
         seg1 = 7'($urandom);
         if ($urandom_range(0, 15) == 0) en = ~en;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         rst = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0; en = 1'b1; req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 20; i++) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
